// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: LEGv8 ID stage with register file, control decoder, immgen and load-use stall.
// Optional: define DECODE_WB_BYPASS_EN to forward same-cycle writeback data to operand reads.
module decode_stage_pipe #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_rs1_data,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic [1:0]        out_alu_op,
    output logic              out_alu_src,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_mem_to_reg,
    output logic              out_reg_write,
    output logic              out_br,
    output logic              out_cbz,
    output logic              out_cbnz,
    output logic              out_illegal
);

    localparam logic [REG_AW-1:0] ZR = REG_AW'(NUM_REGS - 1);

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       br;
        logic       cbz;
        logic       cbnz;
        logic       illegal;
    } ctrl_t;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              is_b, is_cbz, is_cbnz, is_ldur, is_stur, is_r, is_i;
    logic [10:0]       op11;
    logic [9:0]        op10;
    ctrl_t             ctrl, ctrl_q;
    logic [DATA_W-1:0] imm;
    logic              reg2loc, uses_rs1, uses_rs2;
    logic [REG_AW-1:0] rs1, rs2;
    logic [DATA_W-1:0] rs1_data, rs2_data;
    logic              hazard, accept;

    assign op11    = in_instr[31:21];
    assign op10    = in_instr[31:22];
    assign is_b    = in_instr[31:26] == 6'b000101;
    assign is_cbz  = in_instr[31:24] == 8'b10110100;
    assign is_cbnz = in_instr[31:24] == 8'b10110101;
    assign is_ldur = op11 == 11'b11111000010;
    assign is_stur = op11 == 11'b11111000000;
    assign is_r    = (op11 == 11'b10001011000) | (op11 == 11'b11001011000) |
                     (op11 == 11'b10001010000) | (op11 == 11'b10101010000);
    assign is_i    = (op10 == 10'b1001000100) | (op10 == 10'b1101000100);

    always_comb begin
        ctrl     = '0;
        imm      = '0;
        reg2loc  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        unique case (1'b1)
            is_b: begin
                ctrl.br = 1'b1;
                imm     = {{(DATA_W-28){in_instr[25]}}, in_instr[25:0], 2'b00};
            end
            is_cbz, is_cbnz: begin
                ctrl.alu_op = 2'b01;
                ctrl.cbz    = is_cbz;
                ctrl.cbnz   = is_cbnz;
                imm         = {{(DATA_W-21){in_instr[23]}}, in_instr[23:5], 2'b00};
                reg2loc     = 1'b1;
                uses_rs2    = 1'b1;
            end
            is_ldur: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                imm             = {{(DATA_W-9){in_instr[20]}}, in_instr[20:12]};
                uses_rs1        = 1'b1;
            end
            is_stur: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                imm            = {{(DATA_W-9){in_instr[20]}}, in_instr[20:12]};
                reg2loc        = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            is_r: begin
                ctrl.alu_op    = 2'b10;
                ctrl.reg_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            is_i: begin
                ctrl.alu_op    = 2'b11;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                imm            = {{(DATA_W-12){1'b0}}, in_instr[21:10]};
                uses_rs1       = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    assign rs1 = REG_AW'(in_instr[9:5]);
    assign rs2 = reg2loc ? REG_AW'(in_instr[4:0]) : REG_AW'(in_instr[20:16]);

    always_comb begin
        rs1_data = regs[rs1];
        rs2_data = regs[rs2];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_addr == rs1) rs1_data = wb_data;
        if (wb_en && wb_addr == rs2) rs2_data = wb_data;
`endif
        if (rs1 == ZR) rs1_data = '0;
        if (rs2 == ZR) rs2_data = '0;
    end

    // Writeback is independent of the pipeline handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != ZR) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign hazard = in_valid & out_valid & out_mem_read & (out_rd != ZR) &
                    ((uses_rs1 & (rs1 == out_rd)) | (uses_rs2 & (rs2 == out_rd)));

    assign in_ready = rst_n & (~out_valid | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            ctrl_q       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_rs1_data <= rs1_data;
            out_rs2_data <= rs2_data;
            out_imm      <= imm;
            out_rd       <= REG_AW'(in_instr[4:0]);
            ctrl_q       <= ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_alu_op     = ctrl_q.alu_op;
    assign out_alu_src    = ctrl_q.alu_src;
    assign out_mem_read   = ctrl_q.mem_read;
    assign out_mem_write  = ctrl_q.mem_write;
    assign out_mem_to_reg = ctrl_q.mem_to_reg;
    assign out_reg_write  = ctrl_q.reg_write;
    assign out_br         = ctrl_q.br;
    assign out_cbz        = ctrl_q.cbz;
    assign out_cbnz       = ctrl_q.cbnz;
    assign out_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed + random checks of decode_stage_pipe against a behavioural model.
// Honours DECODE_WB_BYPASS_EN the same way as the design.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_rs1_data;
    logic [63:0] out_rs2_data;
    logic [63:0] out_imm;
    logic [4:0]  out_rd;
    logic [1:0]  out_alu_op;
    logic        out_alu_src;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_mem_to_reg;
    logic        out_reg_write;
    logic        out_br;
    logic        out_cbz;
    logic        out_cbnz;
    logic        out_illegal;

    decode_stage_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_rd(out_rd),
        .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
        .out_br(out_br), .out_cbz(out_cbz), .out_cbnz(out_cbnz),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    logic [10:0] obs_ctl;
    assign obs_ctl = {out_alu_op, out_alu_src, out_mem_read, out_mem_write,
                      out_mem_to_reg, out_reg_write, out_br, out_cbz,
                      out_cbnz, out_illegal};

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        chk_rs2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [10:0] ctl;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t last_e;

    // Architectural register state as seen by software.
    logic [63:0] mregs [32];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mregs[i] <= '0;
        end else if (wb_en && wb_addr != 5'd31) begin
            mregs[wb_addr] <= wb_data;
        end
    end

    function automatic logic [63:0] mread(input logic [4:0] idx);
        if (idx == 5'd31) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_addr == idx) return wb_data;
`endif
        return mregs[idx];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc);
        exp_t e;
        longint v;
        logic [1:0] op;
        logic src, mr, mw, m2r, rw, br, cz, cnz, ill;
        e = '0;
        {op, src, mr, mw, m2r, rw, br, cz, cnz, ill} = '0;
        e.pc  = pc;
        e.rd  = ins[4:0];
        e.rs1 = mread(ins[9:5]);
        if (ins[31:26] == 6'b000101) begin
            br = 1; v = $signed(ins[25:0]); e.imm = v * 4;
        end else if (ins[31:25] == 7'b1011010) begin
            op = 2'b01; cz = ~ins[24]; cnz = ins[24];
            v = $signed(ins[23:5]); e.imm = v * 4;
            e.rs2 = mread(ins[4:0]); e.chk_rs2 = 1;
        end else if (ins[31:21] == 11'h7C2) begin
            src = 1; mr = 1; m2r = 1; rw = 1;
            v = $signed(ins[20:12]); e.imm = v;
        end else if (ins[31:21] == 11'h7C0) begin
            src = 1; mw = 1;
            v = $signed(ins[20:12]); e.imm = v;
            e.rs2 = mread(ins[4:0]); e.chk_rs2 = 1;
        end else if (ins[31:21] == 11'h458 || ins[31:21] == 11'h658 ||
                     ins[31:21] == 11'h450 || ins[31:21] == 11'h550) begin
            op = 2'b10; rw = 1;
            e.rs2 = mread(ins[20:16]); e.chk_rs2 = 1;
        end else if (ins[31:22] == 10'h244 || ins[31:22] == 10'h344) begin
            op = 2'b11; src = 1; rw = 1;
            e.imm = 64'(ins[21:10]);
        end else begin
            ill = 1;
        end
        e.ctl = {op, src, mr, mw, m2r, rw, br, cz, cnz, ill};
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input logic [10:0] opc, input int rm, input int rn, input int rd);
        return {opc, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [10:0] rops [4];
        rops = '{11'h458, 11'h658, 11'h450, 11'h550};
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[31:26] = 6'b000101;
            1: w[31:24] = 8'hB4;
            2: w[31:24] = 8'hB5;
            3: w[31:21] = 11'h7C2;
            4: w[31:21] = 11'h7C0;
            5: w[31:21] = rops[$urandom_range(0, 3)];
            6: w[31:22] = ($urandom_range(0, 1) == 1) ? 10'h244 : 10'h344;
            default: ;
        endcase
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bundle(input exp_t e);
        chk("valid", 64'(out_valid), 64'd1);
        chk("pc", out_pc, e.pc);
        chk("rs1", out_rs1_data, e.rs1);
        if (e.chk_rs2) chk("rs2", out_rs2_data, e.rs2);
        chk("imm", out_imm, e.imm);
        chk("rd", 64'(out_rd), 64'(e.rd));
        chk("ctl", 64'(obs_ctl), 64'(e.ctl));
    endtask

    task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = 1'b1;
        #2;
        while (!in_ready && n < 8) begin
            tick();
            #2;
            n++;
        end
        chk("accept_wait", 64'(in_ready), 64'd1);
        last_e = model(ins, pc);
        tick();
        in_valid = 1'b0;
        check_bundle(last_e);
    endtask

    task automatic wb(input logic [4:0] a, input logic [63:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 0; in_valid = 0; in_instr = '0; in_pc = '0; flush = 0;
        wb_en = 0; wb_addr = '0; wb_data = '0; out_ready = 0;
        tick(); tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_fields", out_pc | out_rs1_data | out_rs2_data | out_imm, 64'd0);
        chk("rst_ctl", 64'(obs_ctl), 64'd0);
        rst_n = 1;

        wb(5'd1, 64'h10);
        wb(5'd2, 64'h20);
        wb(5'd4, 64'h44);
        issue(32'h8B020023, 64'h1000);
        chk("add_rs1", out_rs1_data, 64'h10);
        chk("add_rs2", out_rs2_data, 64'h20);
        chk("add_aluop", 64'(out_alu_op), 64'd2);

        // LDUR X5,[X1,#-8] then dependent ADD X6,X5,X2.
        issue({11'h7C2, 9'h1F8, 2'b00, 5'd1, 5'd5}, 64'h1004);
        chk("ldur_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        in_valid = 1; in_instr = enc_r(11'h458, 2, 5, 6); in_pc = 64'h1008;
        out_ready = 1;
        #2;
        chk("hz_ready_low", 64'(in_ready), 64'd0);
        tick();
        chk("hz_bubble", 64'(out_valid), 64'd0);
        #2;
        chk("hz_ready_back", 64'(in_ready), 64'd1);
        e = model(in_instr, in_pc);
        tick();
        in_valid = 0;
        check_bundle(e);

        issue({8'hB4, 19'h7FFFD, 5'd4}, 64'h100C);
        chk("cbz_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF4);
        chk("cbz_flag", 64'(out_cbz), 64'd1);
        chk("cbz_rs2", out_rs2_data, 64'h44);
        issue({6'b000101, 26'd1}, 64'h1010);
        chk("b_imm", out_imm, 64'd4);

        // Back-pressure for three cycles, then flush.
        issue({10'h244, 12'd5, 5'd1, 5'd10}, 64'h1014);
        out_ready = 0; in_valid = 1; in_instr = enc_r(11'h658, 1, 2, 11);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_ready", 64'(in_ready), 64'd0);
            tick();
            check_bundle(last_e);
        end
        flush = 1;
        #2;
        chk("flush_ready", 64'(in_ready), 64'd0);
        tick();
        chk("flush_valid", 64'(out_valid), 64'd0);
        flush = 0; in_valid = 0; out_ready = 1;

        wb(5'd31, 64'hDEAD);
        issue(enc_r(11'h458, 31, 31, 8), 64'h1018);
        chk("xzr_rs1", out_rs1_data, 64'd0);
        chk("xzr_rs2", out_rs2_data, 64'd0);

        issue(32'h0000_0000, 64'h101C);
        chk("ill_ctl", 64'(obs_ctl), 64'd1);

        // Reset while a bundle is held.
        issue(32'h8B020023, 64'h1020);
        out_ready = 0; rst_n = 0;
        tick();
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd0);
        chk("mrst_fields", out_pc | out_rs1_data | out_rs2_data, 64'd0);
        rst_n = 1;
        issue(32'h8B020023, 64'h1024);
        chk("mrst_r1", out_rs1_data, 64'd0);
        chk("mrst_r2", out_rs2_data, 64'd0);

        wb_en = 1; wb_addr = 5'd7; wb_data = 64'h55;
        issue(enc_r(11'h458, 31, 7, 9), 64'h1028);
        wb_en = 0;
`ifdef DECODE_WB_BYPASS_EN
        chk("byp_rs1", out_rs1_data, 64'h55);
`else
        chk("byp_rs1", out_rs1_data, 64'd0);
`endif

        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 1) == 1) wb(5'($urandom), {$urandom, $urandom});
            wb_en   = ($urandom_range(0, 2) == 0);
            wb_addr = 5'($urandom);
            wb_data = {$urandom, $urandom};
            issue(rand_instr(), {$urandom, $urandom});
            wb_en = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
